// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: opcodes, instruction field slices
// and the ID/EX pipeline register layout.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              is_load;
        logic [5:0]        opcode;
    } id_ex_t;

    // Opcodes whose rt field is a source operand (and so can create a load-use hazard).
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Selects one ID operand: $0 reads as zero, a same-cycle writeback wins over
// the register file value.
module operand_bypass #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] field,
    input  logic [DW-1:0] rf_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (field == '0) begin
            operand = '0;
        end else if (wb_en && (wb_reg == field)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID stage decode, writeback bypass and load-use detection, feeding the ID/EX
// pipeline register; also counts stall cycles (saturating).
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_instr,
    input  logic [DW-1:0]    id_pc,
    output logic [AW-1:0]    rf_read_reg_1,
    output logic [AW-1:0]    rf_read_reg_2,
    input  logic [DW-1:0]    rf_read_data_1,
    input  logic [DW-1:0]    rf_read_data_2,
    input  logic             wb_write_en,
    input  logic [AW-1:0]    wb_write_reg,
    input  logic [DW-1:0]    wb_write_data,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_pc,
    output logic [DW-1:0]    ex_rs_data,
    output logic [DW-1:0]    ex_rt_data,
    output logic [DW-1:0]    ex_imm,
    output logic [AW-1:0]    ex_rs,
    output logic [AW-1:0]    ex_rt,
    output logic [AW-1:0]    ex_dest,
    output logic             ex_reg_write,
    output logic             ex_is_load,
    output logic [5:0]       ex_opcode,
    output logic [CNT_W-1:0] stall_count
);

    logic [5:0]       opcode;
    logic [AW-1:0]    rs, rt, rd;
    logic [DW-1:0]    rs_data, rt_data;
    logic [AW-1:0]    dest;
    logic             reg_write;
    logic             is_load;
    logic             hazard;
    id_ex_t           ex_d, ex_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    assign opcode = id_instr[OP_HI:OP_LO];
    assign rs     = id_instr[RS_HI:RS_LO];
    assign rt     = id_instr[RT_HI:RT_LO];
    assign rd     = id_instr[RD_HI:RD_LO];

    assign rf_read_reg_1 = rs;
    assign rf_read_reg_2 = rt;

    operand_bypass #(.DW(DW), .AW(AW)) u_bypass_rs (
        .field   (rs),
        .rf_data (rf_read_data_1),
        .wb_en   (wb_write_en),
        .wb_reg  (wb_write_reg),
        .wb_data (wb_write_data),
        .operand (rs_data)
    );

    operand_bypass #(.DW(DW), .AW(AW)) u_bypass_rt (
        .field   (rt),
        .rf_data (rf_read_data_2),
        .wb_en   (wb_write_en),
        .wb_reg  (wb_write_reg),
        .wb_data (wb_write_data),
        .operand (rt_data)
    );

    always_comb begin
        dest      = '0;
        reg_write = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest      = rd;
                reg_write = 1'b1;
            end
            OP_ADDI: begin
                dest      = rt;
                reg_write = 1'b1;
            end
            OP_LW: begin
                dest      = rt;
                reg_write = 1'b1;
                is_load   = 1'b1;
            end
            default: ;
        endcase
        // Writes to $0 are architecturally discarded.
        if (dest == '0) begin
            reg_write = 1'b0;
        end
    end

    always_comb begin
        hazard = ex_q.valid && ex_q.is_load && id_valid && (ex_q.dest != '0) &&
                 ((ex_q.dest == rs) || ((ex_q.dest == rt) && reads_rt(opcode)));
    end

    assign id_stall = hazard && !flush;

    always_comb begin
        ex_d = '0;
        if (!(flush || hazard)) begin
            ex_d.valid     = id_valid;
            ex_d.pc        = id_pc;
            ex_d.rs_data   = rs_data;
            ex_d.rt_data   = rt_data;
            ex_d.imm       = {{(DW-16){id_instr[IMM_HI]}}, id_instr[IMM_HI:IMM_LO]};
            ex_d.rs        = rs;
            ex_d.rt        = rt;
            ex_d.dest      = dest;
            ex_d.reg_write = reg_write && id_valid;
            ex_d.is_load   = is_load && id_valid;
            ex_d.opcode    = opcode;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs_data   = ex_q.rs_data;
    assign ex_rt_data   = ex_q.rt_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign ex_dest      = ex_q.dest;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_is_load   = ex_q.is_load;
    assign ex_opcode    = ex_q.opcode;
    assign stall_count  = stall_cnt_q;

endmodule
